// File: rtl/mant_mul_seq.sv
// Sequential radix-2 shift-add mantissa multiplier with valid/ready on both sides.
// One multiplier bit is retired per cycle, so latency does not depend on the data.
//
//  state   | meaning
//  --------+--------------------------------------------------------
//  S_IDLE  | ready_o=1, waiting for an operand handshake
//  S_BUSY  | retiring one multiplier bit per cycle, DWIDTH cycles
//  S_DONE  | valid_o=1, product held until the consumer takes it
module mant_mul_seq #(
   parameter  int DWIDTH = 11,
   localparam int CNT_W  = $clog2(DWIDTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [DWIDTH-1:0]     a_i,
   input  logic [DWIDTH-1:0]     b_i,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [2*DWIDTH-1:0]   product_o,
   output logic                  norm_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                state_q;
   logic [2*DWIDTH-1:0]   mcand_q;
   logic [DWIDTH-1:0]     mplier_q;
   logic [2*DWIDTH-1:0]   acc_q;
   logic [2*DWIDTH-1:0]   acc_d;
   logic [CNT_W-1:0]      cnt_q;
   logic                  ready_q;
   logic                  valid_q;
   logic [2*DWIDTH-1:0]   product_q;
   logic                  norm_q;

   // The multiplicand is kept pre-shifted, so no barrel shifter is needed.
   always_comb begin
      acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         ready_q   <= 1'b1;
         valid_q   <= 1'b0;
         product_q <= '0;
         norm_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (valid_i && ready_q) begin
                  mcand_q  <= {{DWIDTH{1'b0}}, a_i};
                  mplier_q <= b_i;
                  acc_q    <= '0;
                  cnt_q    <= '0;
                  ready_q  <= 1'b0;
                  state_q  <= S_BUSY;
               end
            end
            S_BUSY: begin
               acc_q    <= acc_d;
               mplier_q <= mplier_q >> 1;
               mcand_q  <= mcand_q << 1;
               cnt_q    <= cnt_q + CNT_W'(1);
               // Product register is only loaded here, so partial sums never reach product_o.
               if (cnt_q == CNT_W'(DWIDTH - 1)) begin
                  product_q <= acc_d;
                  norm_q    <= acc_d[2*DWIDTH-1];
                  valid_q   <= 1'b1;
                  state_q   <= S_DONE;
               end
            end
            S_DONE: begin
               if (ready_i) begin
                  valid_q <= 1'b0;
                  ready_q <= 1'b1;
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
               ready_q <= 1'b1;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign ready_o   = ready_q;
   assign valid_o   = valid_q;
   assign product_o = product_q;
   assign norm_o    = norm_q;

endmodule

// File: tb/tb_mant_mul_seq.sv
// Bench for mant_mul_seq: directed handshake/latency/reset steps, then a random
// stream checked against a plain a*b reference and an in-order expected-product queue.
module tb_mant_mul_seq;

   localparam int DW = 11;
   localparam int PW = 2 * DW;

   logic          clk = 1'b0;
   logic          rst;
   logic          valid_i;
   logic          ready_o;
   logic [DW-1:0] a_i;
   logic [DW-1:0] b_i;
   logic          valid_o;
   logic          ready_i;
   logic [PW-1:0] product_o;
   logic          norm_o;

   int n_assert = 0;
   int n_fail   = 0;

   mant_mul_seq #(.DWIDTH(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .valid_i   (valid_i),
      .ready_o   (ready_o),
      .a_i       (a_i),
      .b_i       (b_i),
      .valid_o   (valid_o),
      .ready_i   (ready_i),
      .product_o (product_o),
      .norm_o    (norm_o)
   );

   always #5 clk = ~clk;

   function automatic logic [PW-1:0] ref_mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
      longint p;
      p = longint'(a) * longint'(b);
      return PW'(p);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Full transaction with the consumer always ready; latency counted in cycles
   // including the accept cycle itself.
   task automatic do_op(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b);
      int n;
      logic [PW-1:0] exp_p;
      exp_p = ref_mul(a, b);
      ready_i = 1'b1;
      chk({tag, "_ready_before"}, 32'(ready_o), 32'd1);
      a_i = a; b_i = b; valid_i = 1'b1;
      step();
      valid_i = 1'b0;
      a_i = DW'($urandom); b_i = DW'($urandom);
      n = 0;
      while (valid_o !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      chk({tag, "_latency"}, 32'(n + 1), 32'(DW + 1));
      chk({tag, "_product"}, 32'(product_o), 32'(exp_p));
      chk({tag, "_norm"}, 32'(norm_o), 32'(exp_p[PW-1]));
      chk({tag, "_ready_in_done"}, 32'(ready_o), 32'd0);
      step();
      chk({tag, "_valid_drop"}, 32'(valid_o), 32'd0);
      chk({tag, "_ready_back"}, 32'(ready_o), 32'd1);
   endtask

   initial begin
      logic [PW-1:0] q_exp[$];
      logic [PW-1:0] exp_p;
      logic [PW-1:0] held_p;
      logic          held_n;
      logic          hold_pend;
      logic          acc_hs, out_hs;
      int            n_in, n_out, cyc, last_acc, n;

      rst = 1'b1; valid_i = 1'b1; ready_i = 1'b0;
      a_i = 11'h7FF; b_i = 11'h7FF;
      @(negedge clk);
      step();
      step();
      rst = 1'b0; valid_i = 1'b0;
      chk("rst_ready", 32'(ready_o), 32'd1);
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_product", 32'(product_o), 32'd0);
      chk("rst_norm", 32'(norm_o), 32'd0);
      step();
      chk("rst_no_latch", 32'(ready_o), 32'd1);

      do_op("unit", 11'h400, 11'h400);
      do_op("max", 11'h7FF, 11'h7FF);
      do_op("zero", 11'h000, 11'h5A5);

      // Backpressure: product must hold while the consumer stalls.
      exp_p = ref_mul(11'h5A5, 11'h3C3);
      ready_i = 1'b0;
      a_i = 11'h5A5; b_i = 11'h3C3; valid_i = 1'b1;
      step();
      valid_i = 1'b0;
      n = 0;
      while (valid_o !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      chk("bp_latency", 32'(n + 1), 32'(DW + 1));
      for (int i = 0; i < 6; i++) begin
         chk("bp_valid_hold", 32'(valid_o), 32'd1);
         chk("bp_product_hold", 32'(product_o), 32'(exp_p));
         chk("bp_norm_hold", 32'(norm_o), 32'(exp_p[PW-1]));
         chk("bp_ready_low", 32'(ready_o), 32'd0);
         valid_i = i[0];
         a_i = DW'($urandom); b_i = DW'($urandom);
         step();
      end
      valid_i = 1'b0;
      ready_i = 1'b1;
      step();
      chk("bp_valid_drop", 32'(valid_o), 32'd0);
      chk("bp_ready_back", 32'(ready_o), 32'd1);
      step();
      chk("bp_pulses_ignored", 32'(ready_o), 32'd1);

      // Reset in the fourth BUSY cycle.
      a_i = 11'h7FF; b_i = 11'h7FF; valid_i = 1'b1;
      step();
      valid_i = 1'b0;
      step(); step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_valid", 32'(valid_o), 32'd0);
      chk("mid_rst_ready", 32'(ready_o), 32'd1);
      chk("mid_rst_product", 32'(product_o), 32'd0);
      do_op("after_rst", 11'h401, 11'h402);

      // Random stream: valid_i held high, random consumer backpressure.
      n_in = 0; n_out = 0; cyc = 0; last_acc = 0; hold_pend = 1'b0;
      held_p = '0; held_n = 1'b0;
      while (!(n_in == 1000 && n_out == 1000) && cyc < 60000) begin
         if (hold_pend) begin
            chk("rnd_valid_hold", 32'(valid_o), 32'd1);
            chk("rnd_product_hold", 32'(product_o), 32'(held_p));
            chk("rnd_norm_hold", 32'(norm_o), 32'(held_n));
         end
         valid_i = (n_in < 1000);
         ready_i = ($urandom_range(0, 3) != 0);
         a_i = DW'($urandom); b_i = DW'($urandom);
         acc_hs = valid_i && ready_o;
         out_hs = valid_o && ready_i;
         hold_pend = valid_o && !ready_i;
         held_p = product_o; held_n = norm_o;
         if (acc_hs) begin
            if (n_in > 0) chk("rnd_accept_spacing", 32'(cyc - last_acc >= DW + 2), 32'd1);
            last_acc = cyc;
            q_exp.push_back(ref_mul(a_i, b_i));
            n_in++;
         end
         if (out_hs) begin
            if (q_exp.size() == 0) begin
               chk("rnd_unexpected_output", 32'd1, 32'd0);
            end else begin
               exp_p = q_exp.pop_front();
               chk("rnd_product", 32'(product_o), 32'(exp_p));
               chk("rnd_norm", 32'(norm_o), 32'(exp_p[PW-1]));
            end
            n_out++;
         end
         step();
         cyc++;
      end
      valid_i = 1'b0;
      chk("rnd_timeout", 32'(cyc < 60000), 32'd1);
      chk("rnd_in_count", 32'(n_in), 32'd1000);
      chk("rnd_out_count", 32'(n_out), 32'(n_in));
      chk("rnd_queue_empty", 32'(q_exp.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
